// File: rtl/serial_sub_4_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and the bit-counter width helper.
package serial_sub_4_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Counter is one bit wider than needed to index WIDTH so that
    // non-power-of-two widths never wrap before the last step.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_sub_4_if.sv
// Request/result bundle for serial_sub_4. The ovf signal exists only when
// SIGNED_OVF_EN is defined.
interface serial_sub_4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bo;
`ifdef SIGNED_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bi, input busy, done, diff, bo, ovf);
    modport slave  (input start, a, b, bi, output busy, done, diff, bo, ovf);
`else
    modport master (output start, a, b, bi, input busy, done, diff, bo);
    modport slave  (input start, a, b, bi, output busy, done, diff, bo);
`endif
endinterface

// File: rtl/serial_sub_4_full_sub_1.sv
// Combinational 1-bit full subtractor: d = x - y - bin, borrow out in bout.
module full_sub_1 (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generation/propagation.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_sub_4.sv
// Bit-serial subtractor: diff = (a - b - bi) mod 2^WIDTH, one bit per clock,
// LSB first, with start/busy/done handshake.
// Optional feature macro: SIGNED_OVF_EN adds the signed-overflow flag ovf.
module serial_sub_4
    import serial_sub_4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_sub_4_if.slave  bus
);

    localparam int CNT_W = cnt_w(WIDTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             brw;
    logic [WIDTH-1:0] diff_r;
    logic             bo_r;
    logic             d_bit;
    logic             brw_nxt;
    logic             accept;
    logic             last_step;

    full_sub_1 u_fs (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (brw),
        .d    (d_bit),
        .bout (brw_nxt)
    );

    // Start is honoured only when no operation is in flight.
    always_comb begin
        accept    = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
        last_step = (cnt == CNT_W'(WIDTH - 1));
    end

    // Sequencer: IDLE/DONE accept a request, SHIFT runs WIDTH bit-steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        state <= ST_DONE;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand shift registers, running borrow and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            brw    <= 1'b0;
            diff_r <= '0;
            bo_r   <= 1'b0;
        end else if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            brw  <= bus.bi;
        end else if (state == ST_SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            brw    <= brw_nxt;
            diff_r <= {d_bit, diff_r[WIDTH-1:1]};
            if (last_step) begin
                bo_r <= brw_nxt;
            end
        end
    end

`ifdef SIGNED_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_r;

    // Operand sign bits are kept aside since the shift registers lose them;
    // the flag is resolved on the final step when the result MSB appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if ((state == ST_SHIFT) && last_step) begin
            ovf_r <= (a_msb != b_msb) && (d_bit != a_msb);
        end
    end

    assign bus.ovf = ovf_r;
`endif

    assign bus.busy = (state == ST_SHIFT);
    assign bus.done = (state == ST_DONE);
    assign bus.diff = diff_r;
    assign bus.bo   = bo_r;

endmodule

// File: tb/tb_serial_sub_4.sv
// Self-checking bench for serial_sub_4 with a scoreboard queue of expected
// results; define SIGNED_OVF_EN to also check the overflow flag.
module tb_serial_sub_4;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   cyc;
    int   done_cnt;
    exp_t sb[$];

    serial_sub_4_if #(.WIDTH(W)) bus ();

    serial_sub_4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int bi);
        exp_t e;
        int   r;
        int   am;
        r     = a - b - bi;
        e.d   = r[W-1:0];
        e.bo  = (a < (b + bi));
        am    = (a >> (W - 1)) & 1;
        e.ovf = (am != ((b >> (W - 1)) & 1)) && (int'(e.d[W-1]) != am);
        return e;
    endfunction

    // Scoreboard: every done pulse consumes the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("diff", int'(bus.diff), int'(e.d));
                chk("bo", int'(bus.bo), int'(e.bo));
`ifdef SIGNED_OVF_EN
                chk("ovf", int'(bus.ovf), int'(e.ovf));
`endif
            end
        end
    end

    task automatic start_op(input int a, input int b, input int bi);
        @(posedge clk);
        #1;
        bus.a     = W'(a);
        bus.b     = W'(b);
        bus.bi    = bi[0];
        bus.start = 1'b1;
        @(posedge clk);
        sb.push_back(model(a, b, bi));
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        bit seen;
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 3 * W + 4; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) nbusy++;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input int a, input int b, input int bi);
        int n;
        start_op(a, b, bi);
        wait_done(n);
        chk("busy_cycles", n, W);
        @(negedge clk);
        chk("done_pulse_width", int'(bus.done), 0);
    endtask

    initial begin
        int n;
        int t0;
        int t1;
        int dc;
        n_chk     = 0;
        n_pass    = 0;
        cyc       = 0;
        done_cnt  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bi    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_diff", int'(bus.diff), 0);
        chk("rst_bo", int'(bus.bo), 0);
`ifdef SIGNED_OVF_EN
        chk("rst_ovf", int'(bus.ovf), 0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic operations and borrow/wrap boundaries.
        run_op(5, 3, 0);
        run_op(3, 5, 0);
        run_op(0, 0, 1);
        run_op(15, 15, 1);
        run_op(15, 0, 0);

        // Start during SHIFT must be ignored.
        start_op(9, 4, 0);
        @(posedge clk);
        #1;
        bus.a     = W'(1);
        bus.b     = W'(1);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(n);
        @(negedge clk);
        chk("ignored_start_done", int'(bus.done), 0);

        // Back-to-back: start held through DONE.
        @(posedge clk);
        #1;
        bus.a     = W'(12);
        bus.b     = W'(3);
        bus.bi    = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        sb.push_back(model(12, 3, 0));
        #1;
        bus.a = W'(7);
        bus.b = W'(2);
        wait_done(n);
        t0 = cyc;
        @(posedge clk);
        sb.push_back(model(7, 2, 0));
        #1 bus.start = 1'b0;
        chk("no_idle_busy", int'(bus.busy), 1);
        wait_done(n);
        t1 = cyc;
        chk("b2b_gap", t1 - t0, W + 1);
        @(negedge clk);
        chk("b2b_done_width", int'(bus.done), 0);

        // Asynchronous reset in the third SHIFT cycle aborts the operation.
        start_op(10, 3, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        void'(sb.pop_back());
        dc = done_cnt;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_diff", int'(bus.diff), 0);
        chk("abort_bo", int'(bus.bo), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        chk("abort_no_done", done_cnt, dc);
        run_op(11, 4, 1);

        // Signed-overflow cases (diff/bo checked in every build).
        run_op(8, 1, 0);
        run_op(7, 15, 0);
        run_op(6, 2, 0);

        // Random operands.
        for (int i = 0; i < 8; i++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1)));
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
